cpu_run_ctrl: RTL and testbench

//  Run/step/halt sequencer for the RISC-V pipeline on the 50 MHz board clock.

---
 rtl/cpu_run_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step/halt sequencer for the RISC-V pipeline. The pipeline runs on clk and
// advances one stage per cpu_ce pulse. There is no derived clock. The two board
// push buttons are synchronised and debounced here. Each press becomes a
// one-cycle pulse (run_p / step_p) that drives the sequencer FSM.
//
// Parameters
//   TICK_DIV      clk cycles between cpu_ce pulses while running (>= 2)
//   DEBOUNCE_CYC  cycles a synchronised button level must hold before it is
//                 accepted (>= 1)
//   CNT_W         width of ce_count
//
// Ports
//   clk        in   board clock
//   rst        in   asynchronous, active-high reset
//   btn_run    in   raw push button: start / pause / acknowledge halt
//   btn_step   in   raw push button: single step
//   halt_req   in   one-cycle stop request from the pipeline (clk domain)
//   cpu_ce     out  one-cycle pipeline clock enable
//   state_o    out  FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALT
//   running    out  high while in RUN
//   halted     out  high while in HALT
//   led_tick   out  toggles on every cpu_ce (heartbeat LED)
//   ce_count   out  cpu_ce pulses issued since reset (wraps silently)
//
// FSM states
//   state | meaning
//   IDLE  | paused. Waits for a run or step press.
//   RUN   | free running. Issues cpu_ce every TICK_DIV cycles.
//   STEP  | issues exactly one cpu_ce, then returns to IDLE
//   HALT  | pipeline requested stop. Only a run press leaves this state.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [1:0]       state_o,
    output logic             running,
    output logic             halted,
    output logic             led_tick,
    output logic [CNT_W-1:0] ce_count
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Button conditioning. Index 0 is the run button, index 1 is step.
    // ------------------------------------------------------------------
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db_level;
    logic [1:0]      db_prev;
    logic [1:0]      btn_pulse;
    logic [DB_W-1:0] db_cnt [2];

    logic run_p;
    logic step_p;

    assign btn_raw = {btn_step, btn_run};
    assign run_p   = btn_pulse[0];
    assign step_p  = btn_pulse[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            db_level  <= '0;
            db_prev   <= '0;
            btn_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            db_prev   <= db_level;
            // Only a rising debounced level makes a pulse. A release does not.
            btn_pulse <= db_level & ~db_prev;
            for (int i = 0; i < 2; i++) begin
                // Any cycle where the synced level agrees with the accepted
                // level restarts the count. A bounce therefore costs the
                // full DEBOUNCE_CYC again.
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RUN tick divider. It only advances while staying in RUN and is held at
    // zero everywhere else. After entry to RUN, the first cpu_ce therefore
    // comes exactly TICK_DIV cycles later.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    always_comb begin
        tick = (tick_cnt == TICK_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (state == RUN && state_next == RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end else begin
            tick_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Within each state, earlier branches win.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run_p) begin
                    state_next = RUN;
                end else if (step_p) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALT;
                end else if (run_p) begin
                    state_next = IDLE;
                end
            end
            STEP: begin
                if (halt_req) begin
                    state_next = HALT;
                end else begin
                    state_next = IDLE;
                end
            end
            HALT: begin
                if (run_p) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode. This computes what cpu_ce will be next cycle.
    // A halt request always suppresses the enable. A pause press in RUN
    // also suppresses it, even when the press lands on a tick.
    // ------------------------------------------------------------------
    logic ce_next;

    always_comb begin
        ce_next = 1'b0;
        case (state)
            RUN:     ce_next = tick && !halt_req && !run_p;
            STEP:    ce_next = !halt_req;
            default: ce_next = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ce   <= 1'b0;
            running  <= 1'b0;
            halted   <= 1'b0;
            led_tick <= 1'b0;
            ce_count <= '0;
        end else begin
            cpu_ce  <= ce_next;
            running <= (state_next == RUN);
            halted  <= (state_next == HALT);
            if (ce_next) begin
                led_tick <= ~led_tick;
                ce_count <= ce_count + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       halt_req = 1'b0;
    logic       cpu_ce;
    logic [1:0] state_o;
    logic       running;
    logic       halted;
    logic       led_tick;
    logic [3:0] ce_count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    logic exp_led = 1'b0;

    cpu_run_ctrl #(
        .TICK_DIV    (4),
        .DEBOUNCE_CYC(3),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .halt_req(halt_req),
        .cpu_ce  (cpu_ce),
        .state_o (state_o),
        .running (running),
        .halted  (halted),
        .led_tick(led_tick),
        .ce_count(ce_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input bit ce);
        chk({tag, "/state"},    32'(state_o),  32'(st));
        chk({tag, "/running"},  32'(running),  32'(st == 1));
        chk({tag, "/halted"},   32'(halted),   32'(st == 3));
        chk({tag, "/cpu_ce"},   32'(cpu_ce),   32'(ce));
        chk({tag, "/ce_count"}, 32'(ce_count), 32'(exp_cnt));
        chk({tag, "/led_tick"}, 32'(led_tick), 32'(exp_led));
    endtask

    // One clock, then check against the expected state and expected cpu_ce.
    task automatic step_chk(input string tag, input int st, input bit ce);
        tick();
        if (ce) begin
            exp_cnt = (exp_cnt + 1) % 16;
            exp_led = ~exp_led;
        end
        chk_all(tag, st, ce);
    endtask

    task automatic reset_model();
        exp_cnt = 0;
        exp_led = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk_all("reset", 0, 0);
        rst = 1'b0;
        tick();

        // T1: hold run for 10 cycles. Pulse arrives 6 clocks after the press,
        // so RUN begins at 7. The first cpu_ce is at 11, then one every 4.
        btn_run = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            step_chk("t1_run", (k >= 7) ? 1 : 0, (k >= 11) && ((k - 11) % 4 == 0));
            if (k == 10) btn_run = 1'b0;
        end
        chk("t1_count3", 32'(ce_count), 32'd3);

        // T3: halt on the tick cycle (cnt==3 after clock 22) suppresses cpu_ce.
        halt_req = 1'b1;
        step_chk("t3_halt", 3, 0);
        halt_req = 1'b0;
        for (int k = 0; k < 8; k++) step_chk("t3_sticky", 3, 0);
        btn_step = 1'b1;
        for (int k = 0; k < 12; k++) step_chk("t3_step_ign", 3, 0);
        btn_step = 1'b0;
        for (int k = 0; k < 8; k++) step_chk("t3_sticky2", 3, 0);
        btn_run = 1'b1;
        for (int k = 1; k <= 7; k++) step_chk("t3_ack", (k >= 7) ? 0 : 3, 0);
        btn_run = 1'b0;
        for (int k = 0; k < 8; k++) step_chk("t3_idle", 0, 0);

        // halt_req in IDLE is ignored
        halt_req = 1'b1;
        step_chk("idle_halt_ign", 0, 0);
        halt_req = 1'b0;
        step_chk("idle_halt_ign2", 0, 0);

        // T2: step bounces 1,0,1 and then holds 1. The 0 restarts debounce,
        // so STEP starts at clock 9, cpu_ce occurs at 10, and IDLE returns.
        btn_step = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step_chk("t2_step", (k == 9) ? 2 : 0, k == 10);
            btn_step = (k == 1) ? 1'b0 : 1'b1;
        end
        btn_step = 1'b0;
        chk("t2_count4", 32'(ce_count), 32'd4);
        for (int k = 0; k < 8; k++) step_chk("t2_idle", 0, 0);

        // T4: press run and step in the same cycle. Run wins, and STEP never appears.
        btn_run  = 1'b1;
        btn_step = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step_chk("t4_both", (k >= 7) ? 1 : 0, k == 11);
            if (k == 10) begin
                btn_run  = 1'b0;
                btn_step = 1'b0;
            end
        end

        // Reset while running clears everything immediately.
        rst = 1'b1;
        #1;
        reset_model();
        chk_all("rst_run", 0, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) step_chk("rst_run_after", 0, 0);

        // T5: reset lands in the STEP entry cycle, so the pending cpu_ce is dropped.
        btn_step = 1'b1;
        for (int k = 1; k <= 7; k++) step_chk("t5_step", (k == 7) ? 2 : 0, 0);
        rst = 1'b1;
        #1;
        chk_all("t5_rst", 0, 0);
        btn_step = 1'b0;
        tick();
        chk_all("t5_rst_hold1", 0, 0);
        tick();
        chk_all("t5_rst_hold2", 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) step_chk("t5_after", 0, 0);

        // T6: 17 pulses on a 4-bit counter. It reads 15, then 0, then 1 at the end.
        btn_run = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            step_chk("t6_wrap", (k >= 7) ? 1 : 0, (k >= 11) && ((k - 11) % 4 == 0));
            if (k == 10) btn_run = 1'b0;
            if (k == 67) chk("t6_count15", 32'(ce_count), 32'd15);
            if (k == 71) chk("t6_count0", 32'(ce_count), 32'd0);
        end
        chk("t6_count1", 32'(ce_count), 32'd1);
        chk("t6_led", 32'(led_tick), 32'd1);

        // Pause: a run press while in RUN returns to IDLE, and no more pulses follow.
        btn_run = 1'b1;
        for (int k = 1; k <= 7; k++) step_chk("pause", (k == 7) ? 0 : 1, k == 4);
        btn_run = 1'b0;
        for (int k = 0; k < 10; k++) step_chk("pause_idle", 0, 0);
        chk("pause_count2", 32'(ce_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
